// File: rtl/audio_mix_if.sv
// Sample-side bus of the audio mix scheduler: source/gain snapshot inputs,
// control strobes and the mixed stereo result.
interface audio_mix_if #(
    parameter int NCH = 4
);
    logic                 sample_ce;
    logic [16*NCH-1:0]    src;
    logic [8*NCH-1:0]     gain_l;
    logic [8*NCH-1:0]     gain_r;
    logic [NCH-1:0]       ch_en;
    logic                 mute;
    logic                 ovr_clr;
    logic                 busy;
    logic                 out_valid;
    logic [15:0]          out_l;
    logic [15:0]          out_r;
    logic                 overrun;
    logic [7:0]           clip_cnt;

    modport master (
        output sample_ce, src, gain_l, gain_r, ch_en, mute, ovr_clr,
        input  busy, out_valid, out_l, out_r, overrun, clip_cnt
    );

    modport slave (
        input  sample_ce, src, gain_l, gain_r, ch_en, mute, ovr_clr,
        output busy, out_valid, out_l, out_r, overrun, clip_cnt
    );
endinterface

// File: rtl/audio_mix_sched.sv
// Shared-multiplier stereo mixer: snapshot on sample_ce, 2*NCH MACs, saturate, emit.
// Optional clip counter enabled by defining MIX_CLIP_CNT_EN.
//
// state  | meaning
// S_IDLE | waiting for sample_ce
// S_MAC  | one multiply-accumulate per edge, L channels then R channels
// S_SAT  | shift, clamp, mute and register the stereo result
module audio_mix_sched #(
    parameter int NCH    = 4,
    parameter int GSHIFT = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    audio_mix_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW = 25 + $clog2(NCH) + 1;
    localparam logic [IW-1:0]        LAST = IW'(NCH - 1);
    localparam logic signed [AW-1:0] SMAX = AW'(32767);
    localparam logic signed [AW-1:0] SMIN = AW'(-32768);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

    state_t               r_state;
    logic signed [15:0]   r_src [NCH];
    logic [7:0]           r_gl  [NCH];
    logic [7:0]           r_gr  [NCH];
    logic [NCH-1:0]       r_en;
    logic                 r_mute;
    logic [IW-1:0]        r_idx;
    logic                 r_side;
    logic signed [AW-1:0] r_acc_l;
    logic signed [AW-1:0] r_acc_r;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_ovr;
    logic signed [15:0]   r_out_l;
    logic signed [15:0]   r_out_r;

    logic signed [15:0]   w_src;
    logic [7:0]           w_gain;
    logic signed [24:0]   w_prod;
    logic signed [AW-1:0] w_prod_x;
    logic signed [15:0]   w_sat_l;
    logic signed [15:0]   w_sat_r;

    function automatic logic signed [15:0] sat_val(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] v;
        v = acc >>> GSHIFT;
        if (v > SMAX)      return 16'sh7FFF;
        else if (v < SMIN) return 16'sh8000;
        else               return v[15:0];
    endfunction

    always_comb begin
        w_src    = r_src[r_idx];
        w_gain   = r_side ? r_gr[r_idx] : r_gl[r_idx];
        w_prod   = r_en[r_idx] ? (25'(w_src) * 25'($signed({1'b0, w_gain}))) : '0;
        w_prod_x = AW'(w_prod);
        w_sat_l  = sat_val(r_acc_l);
        w_sat_r  = sat_val(r_acc_r);
    end

`ifdef MIX_CLIP_CNT_EN
    logic [7:0] r_clip_cnt;

    function automatic logic is_clip(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] v;
        v = acc >>> GSHIFT;
        return (v > SMAX) || (v < SMIN);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n || bus.ovr_clr) begin
            r_clip_cnt <= '0;
        end else if (r_state == S_SAT && !r_mute && (is_clip(r_acc_l) || is_clip(r_acc_r))
                     && r_clip_cnt != 8'hFF) begin
            r_clip_cnt <= r_clip_cnt + 8'd1;
        end
    end

    assign bus.clip_cnt = r_clip_cnt;
`else
    assign bus.clip_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_en    <= '0;
            r_mute  <= 1'b0;
            r_idx   <= '0;
            r_side  <= 1'b0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_out_l <= '0;
            r_out_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_src[i] <= '0;
                r_gl[i]  <= '0;
                r_gr[i]  <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            // a strobe during a mix is dropped; set beats clear
            if (r_state != S_IDLE && bus.sample_ce) r_ovr <= 1'b1;
            else if (bus.ovr_clr)                   r_ovr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.sample_ce) begin
                        for (int i = 0; i < NCH; i++) begin
                            r_src[i] <= bus.src[16*i +: 16];
                            r_gl[i]  <= bus.gain_l[8*i +: 8];
                            r_gr[i]  <= bus.gain_r[8*i +: 8];
                        end
                        r_en    <= bus.ch_en;
                        r_mute  <= bus.mute;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        r_idx   <= '0;
                        r_side  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (r_side) r_acc_r <= r_acc_r + w_prod_x;
                    else        r_acc_l <= r_acc_l + w_prod_x;
                    if (r_idx == LAST) begin
                        r_idx  <= '0;
                        r_side <= 1'b1;
                        if (r_side) r_state <= S_SAT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_SAT: begin
                    r_out_l <= r_mute ? 16'sd0 : w_sat_l;
                    r_out_r <= r_mute ? 16'sd0 : w_sat_r;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_valid;
    assign bus.out_l     = r_out_l;
    assign bus.out_r     = r_out_r;
    assign bus.overrun   = r_ovr;
endmodule

// File: doc/audio_mix_sched.md
Name: audio_mix_sched

Overview:
- Scheduler for a single shared 16x9 signed multiplier that mixes up to NCH audio sources into one stereo output sample.
- Sits after source conditioning (FM, PSG, SMS FM) and before the final LPF stage.
- On each sample strobe it snapshots all sources and gains, time-multiplexes multiply-accumulates over L and R, saturates the result, and emits one stereo sample with a valid pulse.

Parameters:
- NCH, 4, number of source channels, 1..8.
- GSHIFT, 7, gain fraction bits; gain 2^GSHIFT = unity (0x80).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- sample_ce  in  1  start-mix request, one-cycle strobe.
- src  in  16*NCH  signed source samples; channel i = src[16*i+15:16*i].
- gain_l  in  8*NCH  unsigned left gains per channel.
- gain_r  in  8*NCH  unsigned right gains per channel.
- ch_en  in  NCH  per-channel enable; a disabled channel contributes 0.
- mute  in  1  force a zero output sample.
- ovr_clr  in  1  clears the overrun flag.
- busy  out  1  high while a mix is in progress.
- out_valid  out  1  one-cycle pulse when out_l/out_r update.
- out_l  out  16  signed mixed left sample.
- out_r  out  16  signed mixed right sample.
- overrun  out  1  sticky: sample_ce arrived while busy.
- clip_cnt  out  8  saturating clip counter (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; busy, out_valid, overrun = 0; out_l, out_r = 0; clip_cnt = 0; accumulators cleared. Reset mid-mix aborts the mix with no out_valid.
- States: IDLE -> MAC -> SAT -> IDLE.
- IDLE: at the edge sampling sample_ce=1:
  - snapshot src, gain_l, gain_r, ch_en, mute;
  - clear acc_l, acc_r; idx=0; side=L;
  - go to MAC; busy=1.
- MAC:
  - One multiply per edge: p = src[idx] * $signed({1'b0,gain}) (25-bit signed). gain is gain_l for side L, gain_r for side R; p is forced to 0 if ch_en[idx]=0.
  - Accumulator width 25+clog2(NCH)+1, sign-extended add.
  - Order: L for idx 0..NCH-1, then R for idx 0..NCH-1.
  - After 2*NCH edges, go to SAT.
  - Latency is fixed regardless of ch_en.
- SAT, on one edge:
  - v = acc >>> GSHIFT (arithmetic).
  - Clamp to [-32768, 32767].
  - If snapshot mute=1, result is 0.
  - Register out_l/out_r; out_valid=1 for that cycle only; busy=0; state=IDLE.
- Latency: out_valid is high after edge 2*NCH+1 counted from the edge that sampled sample_ce (edge 0). For NCH=4, that is 9 edges.
- sample_ce while busy (MAC or SAT) is ignored and sets overrun=1. A new sample_ce is accepted on the cycle after out_valid.
- Overrun control:
  - ovr_clr=1 clears overrun.
  - Simultaneous set and ovr_clr: set wins.
- out_l/out_r hold their values between out_valid pulses. Inputs may change freely during busy.

Optional Feature:
- Macro: MIX_CLIP_CNT_EN.
- Defined:
  - clip_cnt increments by 1 per SAT cycle in which L or R clamped, or both (+1 max per sample).
  - Saturates at 255.
  - Muted samples do not count.
  - Cleared by reset and by ovr_clr.
- Undefined: clip_cnt tied to 0; no counter logic.

Test Plan (NCH=4, GSHIFT=7):
- ch0 src=1000, gain_l=0x80, gain_r=0x40, other channels src=0, ch_en=4'hF, pulse sample_ce -> out_valid exactly 9 edges later; out_l=1000, out_r=500; busy high for 9 cycles.
- All src=0x7FFF, all gains 0xFF -> out_l=out_r=32767; clip_cnt=1 with MIX_CLIP_CNT_EN, 0 without. Repeat with all src=0x8000 -> -32768.
- src = {100, -300, 2000, 50}, gain_l = all 0x80, ch_en=4'b1010 -> out_l = -300 + 50 = -250.
- sample_ce at edges 0 and 4 -> one out_valid at edge 9; overrun=1. Then assert ovr_clr -> overrun=0. Then ovr_clr and an overrun sample_ce in the same cycle -> overrun=1.
- mute=1 at the sample_ce edge, then 0 during the mix, with nonzero sources -> out_valid pulses; out_l=out_r=0.
- Mid-MAC (edge 4), reset_n=0 for one cycle -> no out_valid; out_l=out_r=0; busy=0. Then sample_ce -> normal result 9 edges later.
